// File: rtl/regfile_multiport_sb_pkg.sv
// Shared types and default sizes for the multiport register file.
// Optional feature macro: REGFILE_BYPASS_EN (write-through read bypass).
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NRD   = 2;

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_t;

  typedef logic [DEF_XLEN-1:0] rf_word_t;

endpackage

// File: rtl/regfile_multiport_sb_if.sv
// Decode/writeback side bundle of the register file.
// Optional feature macro: REGFILE_BYPASS_EN (no effect on this file).
interface regfile_multiport_sb_if #(
  parameter int XLEN  = regfile_pkg::DEF_XLEN,
  parameter int NREGS = regfile_pkg::DEF_NREGS,
  parameter int NRD   = regfile_pkg::DEF_NRD
);

  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   RD_ADDR;
  logic [NRD*XLEN-1:0] RD_DATA;
  logic [NRD-1:0]      RD_BUSY;
  logic                WR_EN;
  logic [AW-1:0]       WR_ADDR;
  logic [XLEN-1:0]     WR_DATA;
  logic                ISSUE_EN;
  logic [AW-1:0]       ISSUE_ADDR;
  logic                ISSUE_READY;
  logic                READY;

  modport master (
    output RD_ADDR, WR_EN, WR_ADDR, WR_DATA,
    output ISSUE_EN, ISSUE_ADDR,
    input  RD_DATA, RD_BUSY, ISSUE_READY, READY
  );

  modport slave (
    input  RD_ADDR, WR_EN, WR_ADDR, WR_DATA,
    input  ISSUE_EN, ISSUE_ADDR,
    output RD_DATA, RD_BUSY, ISSUE_READY, READY
  );

endinterface

// File: rtl/regfile_multiport_sb_busy_table.sv
// Per-register pending-write scoreboard with NRD read lookups.
// Optional feature macro: REGFILE_BYPASS_EN (no effect on this file).
module regfile_busy_table #(
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         set_en,
  input  logic [$clog2(NREGS)-1:0]     set_addr,
  input  logic                         clr_en,
  input  logic [$clog2(NREGS)-1:0]     clr_addr,
  input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
  output logic [NRD-1:0]               rd_busy,
  input  logic [$clog2(NREGS)-1:0]     iss_addr,
  output logic                         iss_busy
);

  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // set after clear: a same-cycle issue keeps the register reserved
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++)
      rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
  end

  assign iss_busy = busy_q[iss_addr];

endmodule

// File: rtl/regfile_multiport_sb.sv
// Integer register file: NRD read ports, one write port, x0, scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (write-through read bypass).
module regfile_multiport_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = DEF_NRD
) (
  input  logic                   CLK,
  input  logic                   RST,
  regfile_multiport_sb_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  rf_state_t       state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [XLEN-1:0] mem_q [NREGS];

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  logic            run;
  logic            wr_fire;
  logic            iss_busy;
  logic            iss_ready;
  logic            iss_set;
  logic [NRD-1:0]  port_busy;

  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;

  assign run     = (state_q == RF_RUN);
  assign wr_fire = run & bus.WR_EN & (bus.WR_ADDR != '0);

  assign iss_ready = run & ((bus.ISSUE_ADDR == '0) | ~iss_busy |
                     (bus.WR_EN & (bus.WR_ADDR == bus.ISSUE_ADDR)));
  assign iss_set   = bus.ISSUE_EN & iss_ready & (bus.ISSUE_ADDR != '0);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = '0;
    unique case (state_q)
      RF_CLEAR: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + AW'(1);
        if (ptr_q == AW'(NREGS - 1)) state_d = RF_RUN;
      end
      RF_RUN: begin
        mem_we    = wr_fire;
        mem_waddr = bus.WR_ADDR;
        mem_wdata = bus.WR_DATA;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RF_CLEAR;
      ptr_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // storage has no reset; the sweep clears it so it can map to RAM
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) mem_q[mem_waddr] <= mem_wdata;
  end

  regfile_busy_table #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_busy (
    .CLK      (CLK),
    .RST      (RST),
    .set_en   (iss_set),
    .set_addr (bus.ISSUE_ADDR),
    .clr_en   (wr_fire),
    .clr_addr (bus.WR_ADDR),
    .rd_addr  (bus.RD_ADDR),
    .rd_busy  (port_busy),
    .iss_addr (bus.ISSUE_ADDR),
    .iss_busy (iss_busy)
  );

  always_comb begin
    logic [AW-1:0] ra;
    logic          byp;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = bus.RD_ADDR[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      byp = wr_fire & (bus.WR_ADDR == ra);
`else
      byp = 1'b0;
`endif
      if (run && ra != '0) begin
        if (byp) begin
          rd_data[i*XLEN +: XLEN] = bus.WR_DATA;
        end else begin
          rd_data[i*XLEN +: XLEN] = mem_q[ra];
          rd_busy[i]              = port_busy[i];
        end
      end
    end
  end

  assign bus.RD_DATA     = rd_data;
  assign bus.RD_BUSY     = rd_busy;
  assign bus.ISSUE_READY = iss_ready;
  assign bus.READY       = run;

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Directed self-checking bench for regfile_multiport_sb.
// Expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_multiport_sb;
  import regfile_pkg::*;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  regfile_multiport_sb_if rf ();

  regfile_multiport_sb dut (
    .CLK (CLK),
    .RST (RST),
    .bus (rf)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    rf.RD_ADDR    = '0;
    rf.WR_EN      = 1'b0;
    rf.WR_ADDR    = '0;
    rf.WR_DATA    = '0;
    rf.ISSUE_EN   = 1'b0;
    rf.ISSUE_ADDR = '0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rf.RD_ADDR = {a1, a0};
  endtask

  task automatic wr(input logic [4:0] a, input rf_word_t d);
    rf.WR_EN   = 1'b1;
    rf.WR_ADDR = a;
    rf.WR_DATA = d;
  endtask

  task automatic iss(input logic [4:0] a);
    rf.ISSUE_EN   = 1'b1;
    rf.ISSUE_ADDR = a;
  endtask

  function automatic rf_word_t p0();
    return rf.RD_DATA[31:0];
  endfunction

  function automatic rf_word_t p1();
    return rf.RD_DATA[63:32];
  endfunction

  initial begin
    idle();
    RST = 1'b1;
    @(negedge CLK);
    set_rd(5'd1, 5'd3);
    iss(5'd4);
    repeat (3) tick();
    check("rst_ready", rf.READY, 0);
    check("rst_issue_ready", rf.ISSUE_READY, 0);
    check("rst_rd_data", rf.RD_DATA, 0);
    check("rst_rd_busy", rf.RD_BUSY, 0);

    // 1: clear sweep after release
    idle();
    RST = 1'b0;
    #1 check("sweep_ready_k0", rf.READY, 0);
    for (int k = 1; k <= 31; k++) begin
      set_rd(5'(k), 5'd31);
      tick();
      check($sformatf("sweep_ready_k%0d", k), rf.READY, (k == 31));
      if (k < 31) check($sformatf("sweep_data_k%0d", k), rf.RD_DATA, 0);
    end

    // 2: basic write, x0 hardwired
    idle();
    wr(5'd5, 32'hDEADBEEF);
    tick();
    idle();
    set_rd(5'd5, 5'd0);
    #1 check("x5_p0", p0(), 32'hDEADBEEF);
    check("x0_p1", p1(), 0);
    wr(5'd0, 32'h1234);
    tick();
    idle();
    set_rd(5'd0, 5'd0);
    #1 check("x0_after_wr", rf.RD_DATA, 0);
    check("x0_busy", rf.RD_BUSY, 0);

    // 3: same-cycle write and read
    set_rd(5'd7, 5'd5);
    wr(5'd7, 32'hA5A5A5A5);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x7_same_cycle", p0(), 32'hA5A5A5A5);
`else
    check("x7_same_cycle", p0(), 0);
`endif
    check("x7_same_busy", rf.RD_BUSY[0], 0);
    check("x5_other_port", p1(), 32'hDEADBEEF);
    tick();
    idle();
    set_rd(5'd7, 5'd7);
    #1 check("x7_next_p0", p0(), 32'hA5A5A5A5);
    check("x7_next_p1", p1(), 32'hA5A5A5A5);

    // 4: issue then write back
    set_rd(5'd3, 5'd0);
    iss(5'd3);
    #1 check("x3_iss_ready", rf.ISSUE_READY, 1);
    check("x3_busy_same", rf.RD_BUSY[0], 0);
    tick();
    idle();
    set_rd(5'd3, 5'd0);
    #1 check("x3_busy_set", rf.RD_BUSY[0], 1);
    iss(5'd3);
    #1 check("x3_iss_blocked", rf.ISSUE_READY, 0);
    iss(5'd0);
    #1 check("x0_iss_ready", rf.ISSUE_READY, 1);
    idle();
    set_rd(5'd3, 5'd0);
    wr(5'd3, 32'h10);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x3_wr_busy", rf.RD_BUSY[0], 0);
    check("x3_wr_data", p0(), 32'h10);
`else
    check("x3_wr_busy", rf.RD_BUSY[0], 1);
    check("x3_wr_data", p0(), 0);
`endif
    tick();
    idle();
    set_rd(5'd3, 5'd0);
    #1 check("x3_busy_clr", rf.RD_BUSY[0], 0);
    check("x3_data", p0(), 32'h10);

    // 5: issue and write to a busy register in one cycle
    iss(5'd9);
    tick();
    idle();
    set_rd(5'd9, 5'd9);
    #1 check("x9_busy", rf.RD_BUSY, 2'b11);
    iss(5'd9);
    wr(5'd9, 32'h55);
    #1 check("x9_iss_ready", rf.ISSUE_READY, 1);
    tick();
    idle();
    set_rd(5'd9, 5'd9);
    #1 check("x9_p0", p0(), 32'h55);
    check("x9_p1", p1(), 32'h55);
    check("x9_busy_kept", rf.RD_BUSY, 2'b11);

    // 6: reset in the middle of a sweep
    RST = 1'b1;
    tick();
    RST = 1'b0;
    wr(5'd5, 32'hFFFFFFFF);
    repeat (9) tick();
    check("mid_sweep_ready", rf.READY, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    iss(5'd6);
    #1 check("resweep_k0", rf.READY, 0);
    for (int k = 1; k <= 31; k++) begin
      tick();
      check($sformatf("resweep_k%0d", k), rf.READY, (k == 31));
      if (k == 5) check("sweep_iss_ready", rf.ISSUE_READY, 0);
      if (k == 30) idle();
    end
    idle();
    set_rd(5'd5, 5'd9);
    #1 check("x5_wr_lost", p0(), 0);
    check("x9_cleared", p1(), 0);
    check("busy_cleared", rf.RD_BUSY, 0);
    set_rd(5'd6, 5'd7);
    #1 check("x6_not_busy", rf.RD_BUSY[0], 0);
    check("x7_cleared", p1(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
